uart_loopback_tester: RTL and testbench

UART link initiator and checker that drives the far end of the UART echo path. It serializes a known byte pattern onto its `txd`, which connects to the echo design's `rxd`. It deserializes the echo returning on its `rxd` from the echo design's `txd`, compares each echo against the sent byte, and reports pass/fail with an error count. It is used on-board and in simulation to qualify the receiver → FIFO → transmitter echo chain at a given baud rate.

---
 rtl/uart_loopback_tester.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_loopback_tester.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_tester.sv
// UART loopback initiator/checker: sends seed+k one byte at a time (stop-and-wait),
// receives the echo, and counts mismatches, timeouts, framing errors and stray bytes.
module uart_loopback_tester #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned NUM_BYTES      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  seed,
  output logic        txd,
  input  logic        rxd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count
);

  localparam int unsigned BitW = $clog2(CLKS_PER_BIT);
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BitW-1:0] BitLast  = BitW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] HalfLast = BitW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     KLast    = 16'(NUM_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StSend, StWait, StNext, StDone} state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  state_e          state_q, state_d;
  logic [15:0]     k_q, k_d;
  logic [7:0]      seed_q, seed_d;
  logic [BitW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            echo_seen_q, echo_seen_d;
  logic [15:0]     err_q, err_d;
  logic            done_q, done_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [BitW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bits_q, rx_bits_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_ferr_q, rx_ferr_d;

  logic [7:0]  cur_byte;
  logic [9:0]  frame;
  logic        slot_open;
  logic        start_ok;
  logic        fsm_err;
  logic        rx_err;
  logic [16:0] err_sum;

  assign cur_byte  = seed_q + k_q[7:0];
  assign frame     = {1'b1, cur_byte, 1'b0};
  assign slot_open = (state_q == StSend) || (state_q == StWait);
  assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));

  // Combinational from the async-reset state register, so reset forces idle-high at once.
  assign txd       = (state_q == StSend) ? frame[tx_bit_q] : 1'b1;
  assign busy      = (state_q == StSend) || (state_q == StWait) || (state_q == StNext);
  assign done      = done_q;
  assign pass      = done_q && (err_q == 16'd0);
  assign err_count = err_q;

  // Receiver: free-running, 8N1, start bit checked at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_ferr_d  = rx_ferr_q;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bits_d  = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bits_d  = rx_bits_q + 1'b1;
          if (rx_bits_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          rx_ferr_d  = !rx_sync_q;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Main sequencer.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    seed_d   = seed_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    to_cnt_d = to_cnt_q;
    done_d   = done_q;
    fsm_err  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StSend;
          k_d      = '0;
          seed_d   = seed;
          tx_cnt_d = '0;
          tx_bit_d = '0;
          done_d   = 1'b0;
        end
      end
      StSend: begin
        to_cnt_d = '0;
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == 4'd9) state_d = StWait;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StWait: begin
        // An echo landing on the timeout cycle takes precedence over the timeout.
        if (echo_seen_q || rx_valid_q) begin
          state_d = StNext;
        end else if (to_cnt_q == ToLast) begin
          fsm_err = 1'b1;
          state_d = StNext;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StNext: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (k_q == KLast) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          k_d     = k_q + 16'd1;
          state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Only the first byte in a slot is the echo; anything else is a stray byte.
  always_comb begin
    rx_err      = rx_valid_q &&
                  (!slot_open || echo_seen_q || rx_ferr_q || (rx_data_q != cur_byte));
    echo_seen_d = slot_open && (echo_seen_q || rx_valid_q);
    err_sum     = {1'b0, err_q} + 17'(rx_err) + 17'(fsm_err);
    if (start_ok)         err_d = '0;
    else if (err_sum[16]) err_d = 16'hFFFF;
    else                  err_d = err_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      seed_q      <= '0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      to_cnt_q    <= '0;
      echo_seen_q <= 1'b0;
      err_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      seed_q      <= seed_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      to_cnt_q    <= to_cnt_d;
      echo_seen_q <= echo_seen_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bits_q  <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bits_q  <= rx_bits_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_loopback_tester.sv
// Directed bench for uart_loopback_tester: wire loop, delayed echo, silent line,
// bit/stop corruption, stray byte in DONE and reset mid-frame.
module tb_uart_loopback_tester;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Nb  = 4;
  localparam int unsigned To  = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        txd;
  logic        rxd;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // rxd source: 0 wire loop (with optional flip), 1 held high, 2 delayed loop, 3 bench-driven
  logic [1:0]  mode = 2'd0;
  logic        tb_rx = 1'b1;
  logic [39:0] dly = '1;
  int          inj_frame = -1;
  int          inj_lo = 0;
  int          inj_hi = -1;

  // txd frame monitor
  int          mon_n = 0;
  logic        mon_act = 1'b0;
  int          mon_off = 0;
  int          mon_low = 0;
  logic        mon_low_run = 1'b0;
  int          mon_t = 0;
  logic [7:0]  mon_sh = 8'h00;
  logic [7:0]  log_byte [64];
  logic        log_stop [64];
  int          log_t    [64];
  int          log_low  [64];
  logic        flip;

  uart_loopback_tester #(
    .CLKS_PER_BIT  (Cpb),
    .NUM_BYTES     (Nb),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .txd      (txd),
    .rxd      (rxd),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dly <= {dly[38:0], txd};
  end

  assign flip = mon_act && (mon_n == inj_frame) && (mon_off >= inj_lo) && (mon_off <= inj_hi);

  always_comb begin
    unique case (mode)
      2'd0:    rxd = txd ^ flip;
      2'd1:    rxd = 1'b1;
      2'd2:    rxd = dly[39];
      default: rxd = tb_rx;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (txd == 1'b0) begin
        mon_act     <= 1'b1;
        mon_off     <= 1;
        mon_low     <= 1;
        mon_low_run <= 1'b1;
        mon_t       <= cyc;
      end
    end else begin
      mon_off <= mon_off + 1;
      if (mon_low_run) begin
        if (txd == 1'b0) mon_low <= mon_low + 1;
        else             mon_low_run <= 1'b0;
      end
      if (mon_off >= 24 && mon_off <= 136 && (mon_off % 16) == 8) mon_sh <= {txd, mon_sh[7:1]};
      if (mon_off == 152 && mon_n < 64) begin
        log_byte[mon_n] <= mon_sh;
        log_stop[mon_n] <= txd;
        log_t[mon_n]    <= mon_t;
        log_low[mon_n]  <= mon_low;
      end
      if (mon_off == 159) begin
        mon_act <= 1'b0;
        mon_n   <= mon_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] s);
    @(posedge clk); #1;
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int took);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    took = n;
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tb_rx = f[i];
      repeat (Cpb) @(posedge clk);
      #1;
    end
    tb_rx = 1'b1;
  endtask

  initial begin
    int base;
    int took;
    int found;
    logic [7:0] exp_b [4];
    int exp_low [4];
    logic [7:0] exp_wrap [4];

    exp_low[0] = 16; exp_low[1] = 32; exp_low[2] = 16; exp_low[3] = 64;
    exp_wrap[0] = 8'hFE; exp_wrap[1] = 8'hFF; exp_wrap[2] = 8'h00; exp_wrap[3] = 8'h01;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd",  32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err",  32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Wire loop, seed A5
    mode = 2'd0;
    base = mon_n;
    do_start(8'hA5);
    check("s1_busy_n1", 32'(busy), 32'd1);
    check("s1_txd_n1",  32'(txd), 32'd0);
    wait_done(3000, took);
    check("s1_err",  32'(err_count), 32'd0);
    check("s1_pass", 32'(pass), 32'd1);
    check("s1_busy", 32'(busy), 32'd0);
    exp_b[0] = 8'hA5; exp_b[1] = 8'hA6; exp_b[2] = 8'hA7; exp_b[3] = 8'hA8;
    for (int i = 0; i < 4; i++) begin
      check("s1_byte", 32'(log_byte[base + i]), 32'(exp_b[i]));
      check("s1_lowrun", 32'(log_low[base + i]), 32'(exp_low[i]));
      check("s1_stop", 32'(log_stop[base + i]), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      took = log_t[base + i + 1] - log_t[base + i];
      check("s1_spacing", 32'(took >= 161 && took <= 170), 32'd1);
    end

    // Stray 0x55 frame while in DONE
    mode = 2'd3;
    tb_rx = 1'b1;
    drive_byte(8'h55);
    repeat (20) @(posedge clk);
    #1;
    check("s5_err",  32'(err_count), 32'd1);
    check("s5_pass", 32'(pass), 32'd0);
    check("s5_done", 32'(done), 32'd1);

    // Delayed echo, seed FE wraps; second start while busy ignored
    mode = 2'd2;
    base = mon_n;
    do_start(8'hFE);
    check("s2_busy", 32'(busy), 32'd1);
    check("s2_err_clr", 32'(err_count), 32'd0);
    repeat (50) @(posedge clk);
    do_start(8'h00);
    check("s2_busy_after_ignored", 32'(busy), 32'd1);
    wait_done(3000, took);
    check("s2_err",  32'(err_count), 32'd0);
    check("s2_pass", 32'(pass), 32'd1);
    for (int i = 0; i < 4; i++) check("s2_byte", 32'(log_byte[base + i]), 32'(exp_wrap[i]));

    // rxd held high: four timeouts
    mode = 2'd1;
    do_start(8'h30);
    wait_done(4000, took);
    check("s3_err",  32'(err_count), 32'd4);
    check("s3_pass", 32'(pass), 32'd0);
    check("s3_time", 32'(took >= 2230 && took <= 2260), 32'd1);

    // Bit 3 of echo k=2 inverted
    mode = 2'd0;
    inj_frame = mon_n + 2;
    inj_lo = 64;
    inj_hi = 79;
    do_start(8'hA5);
    wait_done(3000, took);
    check("s4a_err",  32'(err_count), 32'd1);
    check("s4a_pass", 32'(pass), 32'd0);

    // Stop bit of echo k=1 forced low
    inj_frame = mon_n + 1;
    inj_lo = 144;
    inj_hi = 159;
    do_start(8'hA5);
    wait_done(3000, took);
    check("s4b_err",  32'(err_count), 32'd1);
    check("s4b_pass", 32'(pass), 32'd0);
    inj_frame = -1;

    // Reset during the start bit of k=1
    base = mon_n;
    do_start(8'hA5);
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk); #1;
      if (mon_n == base + 1 && mon_act && txd == 1'b0) found = 1;
    end
    check("s6_found_k1", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("s6_txd",  32'(txd), 32'd1);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_err",  32'(err_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = mon_n;
    do_start(8'hA5);
    check("s6_restart_txd", 32'(txd), 32'd0);
    wait_done(3000, took);
    check("s6_first_byte", 32'(log_byte[base]), 32'hA5);
    check("s6_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
